// File: rtl/branch_pc_unit.sv
// PC owner and br/jr/jal sequencer sitting downstream of the CON flip-flop.
// Optional per-branch outcome counters are enabled with `define BRANCH_STATS_EN.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [3:0]  LINK_REG = 4'd15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  input  logic        start,
  input  logic        inc_pc,
  input  logic [31:0] bus_in,
  input  logic        con,
  output logic        con_en,
  output logic [31:0] pc_out,
  output logic [31:0] link_out,
  output logic        link_we,
  output logic [3:0]  link_sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] br_taken_cnt,
  output logic [15:0] br_not_taken_cnt
`endif
);

  localparam logic [4:0] OP_BR  = 5'b10010;
  localparam logic [4:0] OP_JR  = 5'b10011;
  localparam logic [4:0] OP_JAL = 5'b10100;

  typedef enum logic [2:0] {
    IDLE, DECODE, COND, RESOLVE, LINK, JUMP, DONE
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [4:0]  op_reg, op_next;
  logic [18:0] c2_reg, c2_next;
  logic        err_reg, err_next;
  logic        taken_reg, taken_next;

  // Only the opcode and the C2 field matter once an instruction is latched.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[26:19];

  always_ff @(posedge clock) begin
    if (clear) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      op_reg    <= '0;
      c2_reg    <= '0;
      err_reg   <= 1'b0;
      taken_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      op_reg    <= op_next;
      c2_reg    <= c2_next;
      err_reg   <= err_next;
      taken_reg <= taken_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    op_next    = op_reg;
    c2_next    = c2_reg;
    err_next   = err_reg;
    taken_next = taken_reg;
    case (state_reg)
      IDLE: begin
        // start has priority; a simultaneous fetch increment is dropped
        if (start) begin
          op_next    = ir[31:27];
          c2_next    = ir[18:0];
          err_next   = 1'b0;
          taken_next = 1'b0;
          state_next = DECODE;
        end else if (inc_pc) begin
          pc_next = pc_reg + 32'd1;
        end
      end
      DECODE: begin
        case (op_reg)
          OP_BR:   state_next = COND;
          OP_JR:   state_next = JUMP;
          OP_JAL:  state_next = LINK;
          default: begin
            err_next   = 1'b1;
            state_next = DONE;
          end
        endcase
      end
      COND:    state_next = RESOLVE;
      RESOLVE: begin
        if (con) begin
          pc_next    = pc_reg + {{13{c2_reg[18]}}, c2_reg};
          taken_next = 1'b1;
        end
        state_next = DONE;
      end
      LINK:    state_next = JUMP;
      JUMP: begin
        pc_next    = bus_in;
        taken_next = 1'b1;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign con_en   = (state_reg == COND);
  assign link_we  = (state_reg == LINK);
  assign link_out = (state_reg == LINK) ? pc_reg : 32'd0;
  assign link_sel = LINK_REG;
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign err      = done & err_reg;
  assign taken    = done & taken_reg;
  assign pc_out   = pc_reg;

`ifdef BRANCH_STATS_EN
  // Index 0 counts taken branches, index 1 not-taken; both saturate.
  logic [1:0]  cnt_inc;
  logic [15:0] cnt_reg [2];

  assign cnt_inc = {(state_reg == RESOLVE) & ~con, (state_reg == RESOLVE) & con};

  for (genvar gi = 0; gi < 2; gi++) begin : g_stat
    always_ff @(posedge clock) begin
      if (clear) begin
        cnt_reg[gi] <= '0;
      end else if (cnt_inc[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
        cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
      end
    end
  end

  assign br_taken_cnt     = cnt_reg[0];
  assign br_not_taken_cnt = cnt_reg[1];
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Randomized self-checking bench for branch_pc_unit against a transaction-level PC model.
// Also exercises the counter outputs when BRANCH_STATS_EN is defined.
module tb_branch_pc_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir;
  logic        start;
  logic        inc_pc;
  logic [31:0] bus_in;
  logic        con = 1'b0;
  logic        con_en;
  logic [31:0] pc_out;
  logic [31:0] link_out;
  logic        link_we;
  logic [3:0]  link_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic        taken;
`ifdef BRANCH_STATS_EN
  logic [15:0] br_taken_cnt;
  logic [15:0] br_not_taken_cnt;
  int          model_taken_cnt;
  int          model_not_taken_cnt;
`endif

  logic        con_d;
  logic [31:0] pc_model;
  int          vectors;
  int          miscompares;

  always #5 clock = ~clock;

  // Stand-in for the upstream CON flip-flop: captures only when enabled.
  always @(posedge clock) if (con_en) con <= con_d;

  branch_pc_unit #(.RESET_PC(32'h0000_0000), .LINK_REG(4'd15)) dut (
    .clock(clock), .clear(clear), .ir(ir), .start(start), .inc_pc(inc_pc),
    .bus_in(bus_in), .con(con), .con_en(con_en), .pc_out(pc_out),
    .link_out(link_out), .link_we(link_we), .link_sel(link_sel),
    .busy(busy), .done(done), .err(err), .taken(taken)
`ifdef BRANCH_STATS_EN
    , .br_taken_cnt(br_taken_cnt), .br_not_taken_cnt(br_not_taken_cnt)
`endif
  );

  task automatic do_inc(input int n);
    @(negedge clock);
    inc_pc = 1'b1;
    repeat (n) @(negedge clock);
    inc_pc = 1'b0;
    pc_model = pc_model + 32'(n);
    vectors++;
    if (pc_out !== pc_model) begin
      miscompares++;
      $display("FAIL inc_pc: pc_out=%h expected=%h", pc_out, pc_model);
    end
  endtask

  // One full instruction; noise adds start/inc_pc alongside start and while busy.
  task automatic run_op(input logic [4:0] op, input logic [18:0] c2,
                        input logic [31:0] busval, input logic conval, input bit noise);
    int          exp_lat, cyc, cen_seen, lk_seen;
    logic [31:0] exp_pc, lo;
    logic [3:0]  ls;
    logic        exp_err, exp_taken, seen;
    int          exp_cen, exp_lk;
    exp_pc = pc_model; exp_err = 1'b0; exp_taken = 1'b0; exp_cen = 0; exp_lk = 0;
    case (op)
      5'b10010: begin
        exp_lat = 4; exp_cen = 1;
        if (conval) begin
          exp_pc = pc_model + 32'($signed(c2));
          exp_taken = 1'b1;
        end
`ifdef BRANCH_STATS_EN
        if (conval) model_taken_cnt++; else model_not_taken_cnt++;
`endif
      end
      5'b10011: begin exp_lat = 3; exp_pc = busval; exp_taken = 1'b1; end
      5'b10100: begin exp_lat = 4; exp_lk = 1; exp_pc = busval; exp_taken = 1'b1; end
      default:  begin exp_lat = 2; exp_err = 1'b1; end
    endcase

    @(negedge clock);
    ir = {op, 8'($urandom), c2};
    start = 1'b1;
    inc_pc = noise;
    bus_in = busval;
    con_d = conval;
    @(negedge clock);
    start = 1'b0; inc_pc = 1'b0; ir = $urandom;
    cyc = 1; cen_seen = 0; lk_seen = 0; seen = 1'b0; lo = '0; ls = '0;
    while (cyc <= 8) begin
      if (con_en) cen_seen++;
      if (link_we) begin lk_seen++; lo = link_out; ls = link_sel; end
      if (done) begin seen = 1'b1; break; end
      if (noise) begin
        start = 1'($urandom); inc_pc = 1'($urandom); ir = $urandom;
      end
      @(negedge clock);
      cyc++;
    end
    start = 1'b0; inc_pc = 1'b0;

    $display("op=%b c2=%h bus=%h con=%b pc_before=%h pc_after=%h done_cycle=%0d err=%b taken=%b",
             op, c2, busval, conval, pc_model, pc_out, cyc, err, taken);
    vectors++;
    if (!seen || cyc != exp_lat) begin
      miscompares++;
      $display("FAIL latency op=%b: done_cycle=%0d seen=%b expected=%0d", op, cyc, seen, exp_lat);
    end
    vectors++;
    if (pc_out !== exp_pc) begin
      miscompares++;
      $display("FAIL pc op=%b: pc_out=%h expected=%h", op, pc_out, exp_pc);
    end
    vectors++;
    if (err !== exp_err || taken !== exp_taken) begin
      miscompares++;
      $display("FAIL flags op=%b: err=%b taken=%b expected err=%b taken=%b",
               op, err, taken, exp_err, exp_taken);
    end
    vectors++;
    if (cen_seen != exp_cen || lk_seen != exp_lk) begin
      miscompares++;
      $display("FAIL strobes op=%b: con_en=%0d link_we=%0d expected %0d %0d",
               op, cen_seen, lk_seen, exp_cen, exp_lk);
    end
    if (exp_lk == 1) begin
      vectors++;
      if (lo !== pc_model || ls !== 4'd15) begin
        miscompares++;
        $display("FAIL link: link_out=%h link_sel=%0d expected %h 15", lo, ls, pc_model);
      end
    end
    pc_model = exp_pc;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || pc_out !== pc_model) begin
      miscompares++;
      $display("FAIL idle_after: busy=%b done=%b pc=%h expected 0 0 %h", busy, done, pc_out, pc_model);
    end
  endtask

  task automatic test_reset;
    clear = 1'b1; start = 1'b0; inc_pc = 1'b0; ir = '0; bus_in = '0; con_d = 1'b0;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    pc_model = 32'h0;
`ifdef BRANCH_STATS_EN
    model_taken_cnt = 0; model_not_taken_cnt = 0;
`endif
    vectors++;
    if (pc_out !== 32'h0 || con_en !== 1'b0 || link_we !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || err !== 1'b0 || taken !== 1'b0 || link_out !== 32'h0 || link_sel !== 4'd15) begin
      miscompares++;
      $display("FAIL reset: pc=%h con_en=%b link_we=%b busy=%b done=%b err=%b taken=%b link_out=%h link_sel=%0d required 0/strobes 0/link_sel 15",
               pc_out, con_en, link_we, busy, done, err, taken, link_out, link_sel);
    end
  endtask

  task automatic test_inc_and_clear;
    do_inc(3);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    pc_model = 32'h0;
    vectors++;
    if (pc_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || con_en !== 1'b0 || link_we !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_after_inc: pc=%h busy=%b done=%b required pc 0, strobes 0", pc_out, busy, done);
    end
  endtask

  task automatic test_directed;
    run_op(5'b10011, 19'h0, 32'h10, 1'b0, 1'b0);         // jr to 0x10
    run_op(5'b10010, 19'h7FFFC, 32'h0, 1'b1, 1'b0);      // br -4 taken -> 0x0C
    run_op(5'b10011, 19'h0, 32'h10, 1'b0, 1'b0);
    run_op(5'b10010, 19'h5, 32'h0, 1'b0, 1'b0);          // br not taken
    run_op(5'b10011, 19'h0, 32'h20, 1'b0, 1'b0);
    run_op(5'b10100, 19'h0, 32'h400, 1'b0, 1'b0);        // jal
  endtask

  task automatic test_wrap_and_illegal;
    run_op(5'b10011, 19'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    do_inc(1);
    run_op(5'b00000, 19'h1234, 32'hDEAD_BEEF, 1'b1, 1'b0);
    run_op(5'b10011, 19'h0, 32'hFFFF_FFF0, 1'b0, 1'b0);
    run_op(5'b10010, 19'h00020, 32'h0, 1'b1, 1'b0);      // positive offset wraps past 0
  endtask

  task automatic test_clear_mid_branch;
    int n;
    run_op(5'b10011, 19'h0, 32'h10, 1'b0, 1'b0);
    @(negedge clock);
    ir = {5'b10010, 8'h00, 19'h7FFFC}; start = 1'b1; con_d = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);   // now in the resolve cycle
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    pc_model = 32'h0;
`ifdef BRANCH_STATS_EN
    model_taken_cnt = 0; model_not_taken_cnt = 0;
`endif
    vectors++;
    if (pc_out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_mid_branch: pc=%h busy=%b done=%b required 0 0 0", pc_out, busy, done);
    end
    n = 0;
    repeat (3) begin
      @(negedge clock);
      if (done) n++;
    end
    vectors++;
    if (n != 0) begin
      miscompares++;
      $display("FAIL abandoned_done: done pulses=%0d required 0", n);
    end
  endtask

  task automatic test_start_with_inc;
    run_op(5'b00000, 19'h0, 32'h0, 1'b0, 1'b1);
    run_op(5'b10010, 19'h3, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_random;
    logic [4:0] op;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: op = 5'b10010;
        1: op = 5'b10011;
        2: op = 5'b10100;
        default: begin
          op = 5'($urandom);
          if (op == 5'b10010 || op == 5'b10011 || op == 5'b10100) op = 5'b11111;
        end
      endcase
      if ($urandom_range(0, 3) == 0) do_inc($urandom_range(1, 4));
      run_op(op, 19'($urandom), $urandom, 1'($urandom), 1'($urandom));
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats;
    vectors++;
    if (br_taken_cnt !== 16'(model_taken_cnt) || br_not_taken_cnt !== 16'(model_not_taken_cnt)) begin
      miscompares++;
      $display("FAIL stats: taken=%0d not_taken=%0d expected %0d %0d",
               br_taken_cnt, br_not_taken_cnt, model_taken_cnt, model_not_taken_cnt);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_inc_and_clear();
    test_directed();
    test_wrap_and_illegal();
    test_clear_mid_branch();
    test_start_with_inc();
    test_random();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter owner and branch/jump sequencer for the mini CPU datapath. It sits directly downstream of the condition (CON) flip-flop. It drives the CON flip-flop's enable, samples the registered condition result, and decides the next PC for `br`, `jr` and `jal`. It also performs the fetch-time PC increment and produces the link value written to R15 on `jal`.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on `clear`.
- `LINK_REG`, default 4'd15: register index reported on `link_sel` for `jal`.

Ports:
- `clock`  input  1  single system clock; all state updates on rising edge.
- `clear`  input  1  synchronous, active-high reset.
- `ir`  input  32  current instruction; opcode `ir[31:27]`, C2 field `ir[18:0]`.
- `start`  input  1  one-cycle strobe; accepted only in IDLE.
- `inc_pc`  input  1  fetch strobe; PC <= PC + 1, honoured only in IDLE.
- `bus_in`  input  32  Ra value (BusMuxOut) for `jr`/`jal` target.
- `con`  input  1  registered CON flip-flop result.
- `con_en`  output  1  drives CONin of the CON flip-flop.
- `pc_out`  output  32  current PC.
- `link_out`  output  32  PC value to be written to the link register.
- `link_we`  output  1  link write strobe.
- `link_sel`  output  4  link register index (= `LINK_REG`).
- `busy`  output  1  high in any state other than IDLE.
- `done`  output  1  one-cycle completion pulse.
- `err`  output  1  valid with `done`; set for unsupported opcode.
- `taken`  output  1  valid with `done`; PC was redirected.

## Operation
- Opcodes: `br` = 5'b10010, `jr` = 5'b10011, `jal` = 5'b10100. Any other opcode: `err`.
- FSM states: IDLE, DECODE, COND, RESOLVE, LINK, JUMP, DONE.
- IDLE + `start`: latch `ir` into an internal register, go to DECODE. Later `ir` changes are ignored.
- DECODE: `br` → COND; `jr` → JUMP; `jal` → LINK; other → DONE with `err`=1, PC unchanged.
- COND: `con_en`=1 for exactly this cycle; the CON flip-flop captures on this edge. → RESOLVE.
- RESOLVE: sample `con`. If 1: PC <= PC + sign_extend(C2[18:0]), `taken`=1. If 0: PC unchanged. → DONE.
- LINK: `link_out`=PC, `link_we`=1, `link_sel`=`LINK_REG`. → JUMP.
- JUMP: PC <= `bus_in` (the value present this cycle), `taken`=1. → DONE.
- DONE: `done`=1; `err` and `taken` hold their latched values. → IDLE.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFF + 1 = 0, and negative offsets wrap.
- `start` and `inc_pc` together in IDLE: `start` wins and the increment is dropped. `inc_pc` while `busy` is ignored.
- `start` while `busy`: ignored, not queued.

## Timing
- Reset values: PC=`RESET_PC`, state IDLE; `con_en`, `link_we`, `busy`, `done`, `err`, `taken` = 0; `link_out` = 0; `link_sel` = `LINK_REG`.
- `clear` takes effect at the next edge from any state. An in-flight instruction is abandoned, no `done` is issued, and PC is reset even mid-branch.
- Latency from the `start` edge to the `done` cycle: `br` 4 cycles, `jr` 3, `jal` 4, illegal 2.
- `pc_out` updates on the edge that ends RESOLVE or JUMP; it is stable by the `done` cycle.
- `con` must be the registered output produced by the COND-cycle enable; the block samples it one cycle later.

## Configuration
- `BRANCH_STATS_EN` defined: adds outputs `br_taken_cnt[15:0]` and `br_not_taken_cnt[15:0]`.
  - Each counter increments in RESOLVE for a `br` and saturates at 16'hFFFF.
  - Both counters clear on `clear`.
- `BRANCH_STATS_EN` undefined: the counter logic and both ports are absent. All other behaviour is identical.

## Test plan
- Reset, then `inc_pc` ×3 → `pc_out` = 3. Holding `clear` for one cycle → `pc_out` = 0 and all strobes 0.
- PC=0x10, `br` with C2=19'h7FFFC (−4), `con`=1 → `con_en` pulses once, `done` in cycle 4, `pc_out`=0x0C, `taken`=1.
- PC=0x10, `br` with C2=5, `con`=0 → `pc_out`=0x10, `taken`=0. With `BRANCH_STATS_EN`, `br_not_taken_cnt`=1.
- PC=0x20, `jal` with `bus_in`=0x400 → `link_we` pulse with `link_out`=0x20 and `link_sel`=15, then `pc_out`=0x400, `done` in cycle 4.
- PC=0xFFFF_FFFF, `inc_pc` → `pc_out`=0. `start` with opcode 5'b00000 → `done` at cycle 2 with `err`=1 and PC unchanged.
- `clear` asserted in RESOLVE of a taken `br` → no `done`, `pc_out`=`RESET_PC`, `busy`=0 next cycle. `start`+`inc_pc` together in IDLE → PC not incremented.
